// File: rtl/execute_stage_cc.sv
// Y86-64 execute stage: ALU, condition evaluation and the architectural ZF/SF/OF register.
// Everything except the CC register is combinational.
module execute_stage_cc #(
    parameter int         WIDTH = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              E_stat,
    input  logic [3:0]              E_Ins_Code,
    input  logic [3:0]              E_Ins_fun,
    input  logic signed [WIDTH-1:0] E_Val_C,
    input  logic signed [WIDTH-1:0] E_value_A,
    input  logic signed [WIDTH-1:0] E_value_B,
    input  logic [3:0]              E_dstE,
    input  logic [3:0]              E_dstM,
    input  logic [2:0]              m_stat,
    input  logic [2:0]              W_stat,
    output logic signed [WIDTH-1:0] e_valE,
    output logic signed [WIDTH-1:0] e_valA,
    output logic                    e_Cnd,
    output logic [3:0]              e_dstE,
    output logic [3:0]              e_dstM,
    output logic [2:0]              e_stat,
    output logic                    ZF,
    output logic                    SF,
    output logic                    OF
);

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_fun;
    logic             of_next;
    logic             set_cc;

    function automatic logic is_exc(input logic [2:0] st);
        return (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    endfunction

    always_comb begin
        alu_a = '0;
        case (E_Ins_Code)
            I_RRMOVQ, I_OPQ:             alu_a = E_value_A;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_Val_C;
            I_CALL, I_PUSHQ:             alu_a = -EIGHT;
            I_RET, I_POPQ:               alu_a = EIGHT;
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_Ins_Code)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:      alu_b = E_value_B;
            default:                     alu_b = '0;
        endcase
    end

    assign alu_fun = (E_Ins_Code == I_OPQ) ? E_Ins_fun : ALU_ADD;

    // Sub is B - A so that a following jXX reads "B cond A".
    always_comb begin
        alu_res = '0;
        of_next = 1'b0;
        case (alu_fun)
            ALU_ADD: begin
                alu_res = alu_b + alu_a;
                of_next = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = alu_b - alu_a;
                of_next = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != alu_b[WIDTH-1]);
            end
            ALU_AND: alu_res = alu_b & alu_a;
            ALU_XOR: alu_res = alu_b ^ alu_a;
            default: alu_res = '0;
        endcase
    end

    // Flags stay put whenever an older or current instruction has faulted.
    assign set_cc = (E_Ins_Code == I_OPQ) && (E_Ins_fun <= ALU_XOR) &&
                    !is_exc(E_stat) && !is_exc(m_stat) && !is_exc(W_stat);

    always_ff @(posedge clk) begin
        if (reset) begin
            ZF <= 1'b1;
            SF <= 1'b0;
            OF <= 1'b0;
        end else if (set_cc) begin
            ZF <= (alu_res == '0);
            SF <= alu_res[WIDTH-1];
            OF <= of_next;
        end
    end

    always_comb begin
        e_Cnd = 1'b0;
        case (E_Ins_fun)
            4'h0:    e_Cnd = 1'b1;
            4'h1:    e_Cnd = (SF ^ OF) | ZF;
            4'h2:    e_Cnd = SF ^ OF;
            4'h3:    e_Cnd = ZF;
            4'h4:    e_Cnd = !ZF;
            4'h5:    e_Cnd = !(SF ^ OF);
            4'h6:    e_Cnd = !(SF ^ OF) && !ZF;
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_valE = alu_res;
    assign e_valA = E_value_A;
    assign e_dstE = ((E_Ins_Code == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;
    assign e_dstM = E_dstM;
    assign e_stat = E_stat;

endmodule

// File: tb/tb_execute_stage_cc.sv
// Directed bench for execute_stage_cc: ALU results, CC update/suppression, conditions, cmov.
module tb_execute_stage_cc;

    logic               clk;
    logic               reset;
    logic [2:0]         E_stat;
    logic [3:0]         E_Ins_Code;
    logic [3:0]         E_Ins_fun;
    logic signed [63:0] E_Val_C;
    logic signed [63:0] E_value_A;
    logic signed [63:0] E_value_B;
    logic [3:0]         E_dstE;
    logic [3:0]         E_dstM;
    logic [2:0]         m_stat;
    logic [2:0]         W_stat;
    logic signed [63:0] e_valE;
    logic signed [63:0] e_valA;
    logic               e_Cnd;
    logic [3:0]         e_dstE;
    logic [3:0]         e_dstM;
    logic [2:0]         e_stat;
    logic               ZF, SF, OF;

    int n_checks = 0;
    int n_errors = 0;

    execute_stage_cc dut (
        .clk(clk), .reset(reset),
        .E_stat(E_stat), .E_Ins_Code(E_Ins_Code), .E_Ins_fun(E_Ins_fun),
        .E_Val_C(E_Val_C), .E_value_A(E_value_A), .E_value_B(E_value_B),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .m_stat(m_stat), .W_stat(W_stat),
        .e_valE(e_valE), .e_valA(e_valA), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
        .e_dstM(e_dstM), .e_stat(e_stat), .ZF(ZF), .SF(SF), .OF(OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] de, input logic [3:0] dm);
        E_stat = st; E_Ins_Code = ic; E_Ins_fun = fn;
        E_Val_C = vc; E_value_A = va; E_value_B = vb;
        E_dstE = de; E_dstM = dm;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cc(input string tag, input logic z, input logic s, input logic o);
        check({tag, ".cc"}, {61'd0, ZF, SF, OF}, {61'd0, z, s, o});
    endtask

    initial begin
        reset = 1'b1; m_stat = 3'd0; W_stat = 3'd0;
        drive(3'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'h0, 4'h0);
        step();
        check_cc("reset", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        drive(3'd1, 4'h6, 4'h0, 64'd0, 64'd5, 64'd3, 4'h3, 4'hF);
        check("add.valE", e_valE, 64'd8);
        check("add.valA", e_valA, 64'd5);
        check("add.pass", {53'd0, e_stat, e_dstE, e_dstM}, {53'd0, 3'd1, 4'h3, 4'hF});
        step();
        check_cc("add", 1'b0, 1'b0, 1'b0);

        drive(3'd1, 4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'h3, 4'hF);
        check("sub_ovf.valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        step();
        check_cc("sub_ovf", 1'b0, 1'b0, 1'b1);

        drive(3'd1, 4'h7, 4'h2, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        check("jl", e_Cnd, 1);
        drive(3'd1, 4'h7, 4'h1, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        check("jle", e_Cnd, 1);
        drive(3'd1, 4'h7, 4'h3, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        check("je", e_Cnd, 0);
        drive(3'd1, 4'h7, 4'h6, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        check("jg", e_Cnd, 0);
        drive(3'd1, 4'h7, 4'h0, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        check("jmp", e_Cnd, 1);
        drive(3'd1, 4'h7, 4'h7, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        check("j_bad", e_Cnd, 0);
        step();
        check_cc("jxx_hold", 1'b0, 1'b0, 1'b1);

        drive(3'd1, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h3, 4'hF);
        check("add_ovf.valE", e_valE, 64'h8000_0000_0000_0000);
        step();
        check_cc("add_ovf", 1'b0, 1'b1, 1'b1);

        drive(3'd1, 4'h6, 4'h3, 64'd0, 64'h1234, 64'h1234, 4'h3, 4'hF);
        check("xor.valE", e_valE, 64'd0);
        step();
        check_cc("xor", 1'b1, 1'b0, 1'b0);

        drive(3'd1, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        check("jne", e_Cnd, 0);
        drive(3'd1, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        check("jge", e_Cnd, 1);

        drive(3'd1, 4'h6, 4'h2, 64'd0, 64'hF0, 64'h3C, 4'h3, 4'hF);
        check("and.valE", e_valE, 64'h30);
        m_stat = 3'd3;
        drive(3'd1, 4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h3, 4'hF);
        check("sub_neg.valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check_cc("m_adr_hold", 1'b1, 1'b0, 1'b0);
        m_stat = 3'd0; W_stat = 3'd2;
        step();
        check_cc("w_hlt_hold", 1'b1, 1'b0, 1'b0);
        W_stat = 3'd0;
        drive(3'd4, 4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h3, 4'hF);
        step();
        check_cc("e_ins_hold", 1'b1, 1'b0, 1'b0);

        drive(3'd1, 4'h6, 4'h0, 64'd0, 64'd5, 64'd3, 4'h3, 4'hF);
        step();
        check_cc("add2", 1'b0, 1'b0, 1'b0);
        drive(3'd1, 4'h6, 4'h4, 64'd0, 64'd5, 64'd3, 4'h3, 4'hF);
        check("op_bad.valE", e_valE, 64'd0);
        step();
        check_cc("op_bad_hold", 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        drive(3'd1, 4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h3, 4'hF);
        check("rst_comb.valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check_cc("rst_prio", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        drive(3'd1, 4'h2, 4'h3, 64'd0, 64'hABC, 64'h777, 4'h2, 4'hF);
        check("cmove_t.cnd", e_Cnd, 1);
        check("cmove_t.dstE", e_dstE, 4'h2);
        check("cmove_t.valE", e_valE, 64'hABC);
        drive(3'd1, 4'h6, 4'h0, 64'd0, 64'd5, 64'd3, 4'h3, 4'hF);
        step();
        drive(3'd1, 4'h2, 4'h3, 64'd0, 64'hABC, 64'h777, 4'h2, 4'hF);
        check("cmove_f.cnd", e_Cnd, 0);
        check("cmove_f.dstE", e_dstE, 4'hF);
        check("cmove_f.valE", e_valE, 64'hABC);
        drive(3'd1, 4'h2, 4'h0, 64'd0, 64'hABC, 64'h777, 4'h2, 4'hF);
        check("rrmov.dstE", e_dstE, 4'h2);
        drive(3'd1, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'h2, 4'hF);
        check("jxx_no_rnone", e_dstE, 4'h2);

        drive(3'd1, 4'hA, 4'h0, 64'd0, 64'h5, 64'h100, 4'h4, 4'hF);
        check("push.valE", e_valE, 64'hF8);
        step();
        drive(3'd1, 4'hB, 4'h0, 64'd0, 64'h5, 64'h100, 4'h4, 4'h3);
        check("pop.valE", e_valE, 64'h108);
        step();
        drive(3'd1, 4'h9, 4'h0, 64'd0, 64'h5, 64'h100, 4'h4, 4'hF);
        check("ret.valE", e_valE, 64'h108);
        step();
        drive(3'd1, 4'h8, 4'h0, 64'h400, 64'h5, 64'h100, 4'h4, 4'hF);
        check("call.valE", e_valE, 64'hF8);
        step();
        drive(3'd1, 4'h5, 4'h0, 64'h10, 64'h5, 64'h20, 4'hF, 4'h3);
        check("mrmov.valE", e_valE, 64'h30);
        step();
        drive(3'd1, 4'h4, 4'h0, 64'h10, 64'h5, 64'h20, 4'hF, 4'hF);
        check("rmmov.valE", e_valE, 64'h30);
        step();
        drive(3'd1, 4'h3, 4'h0, 64'h55, 64'h5, 64'h99, 4'h6, 4'hF);
        check("irmov.valE", e_valE, 64'h55);
        step();
        drive(3'd2, 4'h0, 4'h0, 64'h0, 64'h7, 64'h9, 4'hF, 4'hF);
        check("halt.valE", e_valE, 64'd0);
        step();
        drive(3'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'h0, 4'h0);
        check("bubble.valE", e_valE, 64'd0);
        check("bubble.dstE", e_dstE, 4'h0);
        step();
        check_cc("nonop_hold", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage_cc.md
Name: execute_stage_cc

Overview:
- Y86-64 pipeline execute stage; consumer of the E pipeline register outputs (E_stat, E_Ins_Code, E_Ins_fun, E_Val_C, E_value_A, E_value_B, E_dstE, E_dstM).
- Computes e_valE through the ALU and e_Cnd from the condition codes.
- Owns the architectural condition-code register (ZF/SF/OF), the only sequential state in the stage.
- Feeds the M pipeline register and the forwarding/hazard logic.

Parameters:
- WIDTH, 64, datapath width; all value ports are signed WIDTH.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  pipeline clock; CC updates on posedge.
- reset  in  1  synchronous, active-high reset.
- E_stat  in  3  status of the instruction in E.
- E_Ins_Code  in  4  icode.
- E_Ins_fun  in  4  ifun (ALU op or condition).
- E_Val_C  in  64  constant.
- E_value_A  in  64  operand A.
- E_value_B  in  64  operand B.
- E_dstE  in  4  destination for valE.
- E_dstM  in  4  destination for valM.
- m_stat  in  3  status of the instruction in the memory stage.
- W_stat  in  3  status of the instruction in write-back.
- e_valE  out  64  ALU result.
- e_valA  out  64  E_value_A pass-through.
- e_Cnd  out  1  condition result for jXX/cmovXX.
- e_dstE  out  4  E_dstE, or RNONE on a failed cmov.
- e_dstM  out  4  E_dstM pass-through.
- e_stat  out  3  E_stat pass-through.
- ZF, SF, OF  out  1 each  CC register contents.

Behaviour:
- Stat codes: 0 = bubble/AOK, 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS. Exceptional means 2, 3 or 4.
- icodes: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- aluA selection:
  - icode 2 or 6: E_value_A.
  - icode 3, 4, 5: E_Val_C.
  - icode 8 or A: -8.
  - icode 9 or B: +8.
  - otherwise: 0.
- aluB selection:
  - icode 4, 5, 6, 8, 9, A, B: E_value_B.
  - icode 2, 3: 0.
  - otherwise: 0.
- alufun: icode 6 uses E_Ins_fun (0 add, 1 sub, 2 and, 3 xor); every other icode adds. Ifun values above 3 on OPq produce e_valE = 0 and do not set CC.
- e_valE = aluB op aluA. Sub is aluB − aluA. Result wraps modulo 2^64.
- Combinational latency: e_valE, e_Cnd, e_dstE and all pass-throughs are valid in the same cycle, with no registers.
- Flag computation (applied at the edge, from the ALU result):
  - ZF = result == 0.
  - SF = result[63].
  - OF for add: aluA[63] == aluB[63] and result[63] != aluA[63].
  - OF for sub: aluA[63] != aluB[63] and result[63] != aluB[63].
  - OF for and/xor: 0.
- set_cc = (icode == 6) and ifun ≤ 3 and E_stat not exceptional and m_stat not exceptional and W_stat not exceptional.
- CC update: on posedge clk, if set_cc, load the flags. Otherwise hold.
- Reset: on posedge with reset = 1, ZF = 1, SF = 0, OF = 0. Reset takes priority over set_cc in the same cycle. Combinational outputs are unaffected by reset.
- e_Cnd is computed from the current (pre-edge) CC, so an OPq followed by a jXX sees the OPq flags one cycle later, as required by the pipeline:
  - ifun 0: always 1.
  - ifun 1 (le): (SF^OF) | ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF) & !ZF.
  - ifun > 6: 0.
- e_dstE = RNONE when icode == 2 and e_Cnd == 0; otherwise E_dstE.
- Bubble input (icode 1, all zero): e_valE = 0, e_dstE = 0, CC unchanged.

Test Plan:
- Reset: assert reset for 1 cycle → ZF = 1, SF = 0, OF = 0. Then OPq add 5 + 3 → e_valE = 8; after the edge ZF = 0, SF = 0, OF = 0.
- OPq sub with valA = 1, valB = 0x8000000000000000 → e_valE = 0x7FFFFFFFFFFFFFFF; after the edge OF = 1, SF = 0, ZF = 0. Next cycle jXX ifun 2 (l) → e_Cnd = 1.
- OPq add 0x7FFF…F + 1 → e_valE = 0x8000…0, OF = 1, SF = 1. OPq xor with equal operands → e_valE = 0, ZF = 1, OF = 0.
- CC suppression: OPq with m_stat = 3 (ADR) → CC held at its previous values. OPq with W_stat = 2 → CC held. OPq while reset is high → CC takes the reset values.
- cmovXX ifun 3 with ZF = 0, E_dstE = 4'h2 → e_Cnd = 0, e_dstE = 4'hF, e_valE = valA. With ZF = 1 → e_dstE = 4'h2.
- Stack ops: pushq with valB = 0x100 → e_valE = 0xF8. popq/ret with valB = 0x100 → 0x108. mrmovq with valC = 0x10, valB = 0x20 → 0x30. None of these change CC.
